// File: rtl/rv_isa_pkg.sv
// RV32I opcode, immediate-format and loader FSM definitions shared by the
// instruction encoder/loader and the control decode path.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [1:0] imm_src_t;
  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
  localparam state_t ST_ERROR = 2'd3;

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I field packer: builds the instruction word for the five
// supported opcode classes and flags tuples that cannot be encoded.
module instr_packer
  import rv_isa_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic imm12_ok;
  logic imm13_ok;

  // A value fits a signed N-bit field when all bits from N-1 upward agree.
  assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        word = {funct7, rs2, rs1, funct3, rd, op};
      end
      OP_IALU, OP_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, op};
        illegal = ~imm12_ok;
      end
      OP_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        illegal = ~imm12_ok;
      end
      OP_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        illegal = ~imm13_ok;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads an encoded RV32I program into instruction memory, one word per
// accepted tuple, while holding the core in reset until the load completes.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 1024,
  localparam int                   CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [6:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a tuple transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid, and the tuple must be
  // held stable by the source until it transfers.
  state_t      state;
  logic        last_seen;
  logic        accept;
  logic        illegal;
  logic [31:0] word;

  instr_packer u_packer (
    .op      (in_op),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  // After the final tuple is taken, input stays closed until DONE is reached
  // one cycle after its write.
  assign in_ready = (state == ST_LOAD) && !last_seen && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERROR);
  assign cpu_hold = (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_seen <= 1'b0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      // start overrides everything, including a tuple accepted this edge.
      if (start) begin
        state     <= ST_LOAD;
        last_seen <= 1'b0;
        count     <= '0;
        mem_addr  <= BASE_ADDR;
      end else if (state == ST_LOAD) begin
        if (last_seen) begin
          state     <= ST_DONE;
          last_seen <= 1'b0;
        end else if (accept) begin
          if (illegal) begin
            state <= ST_ERROR;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + (ADDR_WIDTH'(count) << 2);
            mem_wdata <= word;
            count     <= count + 1'b1;
            last_seen <= in_last;
          end
        end
      end
    end
  end

endmodule
